// File: rtl/candy_vend_ctrl_param.sv
// -----------------------------------------------------------------------------
// candy_vend_ctrl_param
//
// Parametrised Moore vending controller. Credit builds up from decoded coin
// strobes. One candy is dispensed when the credit reaches PRICE. Change and
// refunds are paid out as 10/5 coin pulses.
//
// Build option:
//   CHANGE_RETURN_EN  defined   -> the post-sale remainder is paid out via PAYOUT
//                     undefined -> the remainder stays as credit for the next sale
//                                  (it can still be recovered with cancel)
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous, active-high reset
//   coin[3:0]    in   coin code, qualified by coin_valid
//   coin_valid   in   one-cycle strobe per inserted coin
//   cancel       in   refund request for the current credit
//   candy        out  dispense pulse, one cycle per sale
//   chg10        out  pay out one 10-rupee coin
//   chg5         out  pay out one 5-rupee coin
//   coin_accept  out  high the cycle after an accepted coin
//   coin_reject  out  high the cycle after a rejected coin
//   busy         out  high in any state other than COLLECT
//   credit       out  current credit in rupees
// -----------------------------------------------------------------------------
module candy_vend_ctrl_param #(
  parameter int unsigned PRICE      = 15,
  parameter int unsigned MAX_CREDIT = 40,
  parameter int unsigned CREDIT_W   = 6,
  parameter logic [3:0]  CODE_R5    = 4'b0101,
  parameter logic [3:0]  CODE_R10   = 4'b1010,
  parameter logic [3:0]  CODE_R20   = 4'b1111
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          coin,
  input  logic                coin_valid,
  input  logic                cancel,
  output logic                candy,
  output logic                chg10,
  output logic                chg5,
  output logic                coin_accept,
  output logic                coin_reject,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_VEND    = 2'd1,
    S_PAYOUT  = 2'd2
  } state_t;

  localparam logic [CREDIT_W-1:0] VAL5    = CREDIT_W'(5);
  localparam logic [CREDIT_W-1:0] VAL10   = CREDIT_W'(10);
  localparam logic [CREDIT_W-1:0] VAL20   = CREDIT_W'(20);
  localparam logic [CREDIT_W-1:0] MAX_C   = CREDIT_W'(MAX_CREDIT);
  localparam logic [CREDIT_W:0]   PRICE_X = (CREDIT_W+1)'(PRICE);

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                candy_q, candy_d;
  logic                chg10_q, chg10_d;
  logic                chg5_q, chg5_d;
  logic                accept_q, accept_d;
  logic                reject_q, reject_d;
  logic                busy_q, busy_d;

  logic                coin_known;
  logic                coin_fits;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W:0]   sum_x;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d    = state_q;
    credit_d   = credit_q;
    accept_d   = 1'b0;
    reject_d   = 1'b0;
    coin_known = 1'b1;
    coin_val   = '0;

    case (coin)
      CODE_R5:  coin_val = VAL5;
      CODE_R10: coin_val = VAL10;
      CODE_R20: coin_val = VAL20;
      default:  coin_known = 1'b0;
    endcase

    // Overflow test written as credit <= MAX - value so the sum never needs
    // to be formed before it is known to fit.
    coin_fits = (coin_val <= MAX_C) && (credit_q <= MAX_C - coin_val);
    sum_x     = {1'b0, credit_q + coin_val};

    case (state_q)
      S_COLLECT: begin
        if (cancel) begin
          // A coin arriving together with cancel is bounced; cancel wins.
          reject_d = coin_valid;
          if (credit_q != '0) state_d = S_PAYOUT;
        end else if (coin_valid) begin
          if (coin_known && coin_fits) begin
            accept_d = 1'b1;
            credit_d = credit_q + coin_val;
            if (sum_x >= PRICE_X) state_d = S_VEND;
          end else begin
            reject_d = 1'b1;
          end
        end
      end

      S_VEND: begin
        reject_d = coin_valid;
        credit_d = CREDIT_W'({1'b0, credit_q} - PRICE_X);
`ifdef CHANGE_RETURN_EN
        state_d  = (credit_d != '0) ? S_PAYOUT : S_COLLECT;
`else
        state_d  = S_COLLECT;
`endif
      end

      S_PAYOUT: begin
        reject_d = coin_valid;
        // Credit is always a non-zero multiple of 5 here.
        if (credit_q >= VAL10) credit_d = credit_q - VAL10;
        else                   credit_d = credit_q - VAL5;
        if (credit_d == '0) state_d = S_COLLECT;
      end

      default: state_d = S_COLLECT;
    endcase

    // Outputs are registered from the next state so that each one is valid
    // for the whole cycle the FSM spends in the matching state.
    candy_d = (state_d == S_VEND);
    busy_d  = (state_d != S_COLLECT);
    chg10_d = (state_d == S_PAYOUT) && (credit_d >= VAL10);
    chg5_d  = (state_d == S_PAYOUT) && (credit_d <  VAL10);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_COLLECT;
      credit_q <= '0;
      candy_q  <= 1'b0;
      chg10_q  <= 1'b0;
      chg5_q   <= 1'b0;
      accept_q <= 1'b0;
      reject_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      candy_q  <= candy_d;
      chg10_q  <= chg10_d;
      chg5_q   <= chg5_d;
      accept_q <= accept_d;
      reject_q <= reject_d;
      busy_q   <= busy_d;
    end
  end

  assign candy       = candy_q;
  assign chg10       = chg10_q;
  assign chg5        = chg5_q;
  assign coin_accept = accept_q;
  assign coin_reject = reject_q;
  assign busy        = busy_q;
  assign credit      = credit_q;

endmodule

// File: tb/tb_candy_vend_ctrl_param.sv
// -----------------------------------------------------------------------------
// tb_candy_vend_ctrl_param
//
// Bench for candy_vend_ctrl_param with PRICE=15, MAX_CREDIT=40.
// The vector table describes the default build (CHANGE_RETURN_EN undefined,
// so a sale remainder stays as credit). The hand-written change sequence
// follows whichever build is compiled.
// Observed word layout: {candy, chg10, chg5, coin_accept, coin_reject, busy,
// credit[5:0]}.
// -----------------------------------------------------------------------------
module tb_candy_vend_ctrl_param;

  localparam logic [3:0] R5  = 4'b0101;
  localparam logic [3:0] R10 = 4'b1010;
  localparam logic [3:0] R20 = 4'b1111;
  localparam logic [3:0] BAD = 4'b0011;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] coin;
  logic       coin_valid;
  logic       cancel;
  logic       candy, chg10, chg5, coin_accept, coin_reject, busy;
  logic [5:0] credit;

  candy_vend_ctrl_param dut (
    .clk         (clk),
    .rst         (rst),
    .coin        (coin),
    .coin_valid  (coin_valid),
    .cancel      (cancel),
    .candy       (candy),
    .chg10       (chg10),
    .chg5        (chg5),
    .coin_accept (coin_accept),
    .coin_reject (coin_reject),
    .busy        (busy),
    .credit      (credit)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        cv;
    logic [3:0]  coin;
    logic        cancel;
    logic [11:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [11:0] exp_q[$];
  int          checks   = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  task automatic add(input logic r, input logic cv, input logic [3:0] c, input logic can,
                     input logic e_candy, input logic e_c10, input logic e_c5,
                     input logic e_acc, input logic e_rej, input logic e_busy,
                     input logic [5:0] e_credit);
    vec_t v;
    v.rst    = r;
    v.cv     = cv;
    v.coin   = c;
    v.cancel = can;
    v.exp    = {e_candy, e_c10, e_c5, e_acc, e_rej, e_busy, e_credit};
    vecs.push_back(v);
  endtask

  function automatic logic [11:0] observe();
    return {candy, chg10, chg5, coin_accept, coin_reject, busy, credit};
  endfunction

  task automatic idle_inputs();
    coin_valid = 1'b0;
    coin       = 4'b0000;
    cancel     = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    idle_inputs();

    //  rst cv coin cancel | candy c10 c5 acc rej busy credit
    add(1, 0, 4'b0, 0,   0, 0, 0, 0, 0, 0, 6'd0);   // reset state
    // R5 then R10: sale at exactly PRICE
    add(0, 1, R5,   0,   0, 0, 0, 1, 0, 0, 6'd5);
    add(0, 1, R10,  0,   1, 0, 0, 1, 0, 1, 6'd15);
    add(0, 0, 4'b0, 0,   0, 0, 0, 0, 0, 0, 6'd0);
    // R10 then R20: remainder 15 kept as credit
    add(0, 1, R10,  0,   0, 0, 0, 1, 0, 0, 6'd10);
    add(0, 1, R20,  0,   1, 0, 0, 1, 0, 1, 6'd30);
    add(0, 0, 4'b0, 0,   0, 0, 0, 0, 0, 0, 6'd15);
    // Build up carried credit to 25, reaching MAX_CREDIT on the way
    add(0, 1, R20,  0,   1, 0, 0, 1, 0, 1, 6'd35);
    add(0, 0, 4'b0, 0,   0, 0, 0, 0, 0, 0, 6'd20);
    add(0, 1, R20,  0,   1, 0, 0, 1, 0, 1, 6'd40);
    add(0, 0, 4'b0, 0,   0, 0, 0, 0, 0, 0, 6'd25);
    // R20 at credit 25 would overflow: rejected
    add(0, 1, R20,  0,   0, 0, 0, 0, 1, 0, 6'd25);
    // Refund 25: 10, 10, 5; cancel and coin ignored during payout
    add(0, 0, 4'b0, 1,   0, 1, 0, 0, 0, 1, 6'd25);
    add(0, 1, R5,   1,   0, 1, 0, 0, 1, 1, 6'd15);
    add(0, 0, 4'b0, 0,   0, 0, 1, 0, 0, 1, 6'd5);
    add(0, 0, 4'b0, 0,   0, 0, 0, 0, 0, 0, 6'd0);
    // R10 then cancel
    add(0, 1, R10,  0,   0, 0, 0, 1, 0, 0, 6'd10);
    add(0, 0, 4'b0, 1,   0, 1, 0, 0, 0, 1, 6'd10);
    add(0, 0, 4'b0, 0,   0, 0, 0, 0, 0, 0, 6'd0);
    // cancel with zero credit is ignored
    add(0, 0, 4'b0, 1,   0, 0, 0, 0, 0, 0, 6'd0);
    // Coin during VEND and unknown code: rejected
    add(0, 1, R5,   0,   0, 0, 0, 1, 0, 0, 6'd5);
    add(0, 1, R10,  0,   1, 0, 0, 1, 0, 1, 6'd15);
    add(0, 1, R20,  0,   0, 0, 0, 0, 1, 0, 6'd0);
    add(0, 1, BAD,  0,   0, 0, 0, 0, 1, 0, 6'd0);
    // Unknown code at non-zero credit, then R20 together with cancel
    add(0, 1, R10,  0,   0, 0, 0, 1, 0, 0, 6'd10);
    add(0, 1, BAD,  0,   0, 0, 0, 0, 1, 0, 6'd10);
    add(0, 1, R20,  1,   0, 1, 0, 0, 1, 1, 6'd10);
    add(0, 0, 4'b0, 0,   0, 0, 0, 0, 0, 0, 6'd0);
    // Coin with cancel at zero credit: rejected, stays in COLLECT
    add(0, 1, R5,   1,   0, 0, 0, 0, 1, 0, 6'd0);
    // Reset during a payout of 15 (coin strobe alongside is overridden)
    add(0, 1, R10,  0,   0, 0, 0, 1, 0, 0, 6'd10);
    add(0, 1, R20,  0,   1, 0, 0, 1, 0, 1, 6'd30);
    add(0, 0, 4'b0, 0,   0, 0, 0, 0, 0, 0, 6'd15);
    add(0, 0, 4'b0, 1,   0, 1, 0, 0, 0, 1, 6'd15);
    add(1, 1, R5,   0,   0, 0, 0, 0, 0, 0, 6'd0);
    add(0, 0, 4'b0, 0,   0, 0, 0, 0, 0, 0, 6'd0);

    // Table: inputs driven on the falling edge, expectation queued at the
    // same time, popped and compared just after the next rising edge.
    for (int i = 0; i < vecs.size(); i++) begin
      logic [11:0] want;
      @(negedge clk);
      rst        = vecs[i].rst;
      coin_valid = vecs[i].cv;
      coin       = vecs[i].coin;
      cancel     = vecs[i].cancel;
      exp_q.push_back(vecs[i].exp);
      @(posedge clk);
      #1;
      want = exp_q.pop_front();
      check($sformatf("vec%0d", i), 32'(observe()), 32'(want));
    end

    // Latency: last coin strobe at N -> candy at N+1, for one cycle only.
    @(negedge clk);
    coin_valid = 1'b1;
    coin       = R5;
    @(negedge clk);
    coin       = R10;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      idle_inputs();
      n++;
    end while (!candy && n < 8);
    check("lat_candy_cycles", 32'(n), 32'd1);
    @(posedge clk);
    #1;
    check("lat_candy_width", 32'(candy), 32'd0);
    check("lat_credit", 32'(credit), 32'd0);
    check("lat_no_change", 32'({chg10, chg5}), 32'd0);

    // R10 + R20: sale with 15 left over, behaviour depends on the build.
    @(negedge clk);
    coin_valid = 1'b1;
    coin       = R10;
    @(negedge clk);
    coin       = R20;
    @(posedge clk);
    #1;
    idle_inputs();
    check("chg_candy", 32'(candy), 32'd1);
`ifdef CHANGE_RETURN_EN
    @(posedge clk);
    #1;
    check("chg_first10", 32'({chg10, chg5, busy}), 32'b101);
    @(posedge clk);
    #1;
    check("chg_then5", 32'({chg10, chg5, busy}), 32'b011);
    @(posedge clk);
    #1;
    check("chg_done_credit", 32'({busy, credit}), 32'd0);
`else
    @(posedge clk);
    #1;
    check("keep_credit", 32'({chg10, chg5, busy, credit}), 32'd15);
    @(posedge clk);
    #1;
    check("keep_idle", 32'({chg10, chg5, busy, credit}), 32'd15);
    @(negedge clk);
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    check("keep_refund10", 32'({chg10, chg5, busy}), 32'b101);
    @(posedge clk);
    #1;
    check("keep_refund5", 32'({chg10, chg5, busy}), 32'b011);
    @(posedge clk);
    #1;
    check("keep_refund_done", 32'({busy, credit}), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
